// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Decoupling queue between instruction fetch and decode. Holds DEPTH
//   {pc, instruction} pairs, accepts them from fetch with a valid/ready
//   handshake and presents them to decode in arrival order. A one-cycle
//   flush discards everything on a branch/jump redirect.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   XLEN   width of the pc and instruction fields
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   fetch offers {in_pc, in_instr}
//   in_pc      in   pc of the offered instruction
//   in_instr   in   offered instruction word
//   in_ready   out  queue can accept (not full); push = in_valid & in_ready
//   out_valid  out  head entry valid (not empty)
//   out_pc     out  head pc (0 when empty)
//   out_instr  out  head instruction (NOP 0x00000013 when empty)
//   out_ready  in   decode consumes; pop = out_valid & out_ready
//   flush      in   discard all entries, including any same-cycle push/pop
//   count      out  current occupancy
//
// Build option
//   IF_ID_QUEUE_TRACE_EN  when defined, prints a line for every accepted
//                         push, pop and flush. No functional effect.
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  logic [XLEN-1:0]  r_pc_mem    [DEPTH];
  logic [XLEN-1:0]  r_instr_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Status comes only from the registered count, so in_ready never sees
  // out_ready combinationally and reset clears the outputs immediately.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_pc    = w_empty ? '0        : r_pc_mem[r_rd_ptr];
  assign out_instr = w_empty ? NOP_INSTR : r_instr_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // from DEPTH-1 to 0 by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array is deliberately not reset; a write is suppressed by
  // flush so a redirected fetch never lands in the queue.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_instr_mem[r_wr_ptr] <= in_instr;
    end
  end

`ifdef IF_ID_QUEUE_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (flush) begin
        $display("IFQ FLUSH: dropped=%0d", r_count);
      end else begin
        if (w_push) $display("IFQ PUSH: PC=0x%08h INSTR=0x%08h", in_pc, in_instr);
        if (w_pop)  $display("IFQ POP: PC=0x%08h INSTR=0x%08h", out_pc, out_instr);
      end
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= CNT_W'(DEPTH))
        else $error("if_id_queue: occupancy above DEPTH");
      assert (!(in_valid && in_ready && w_full))
        else $error("if_id_queue: push while full");
      assert (!(out_valid && out_ready && w_empty))
        else $error("if_id_queue: pop while empty");
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q [$];

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever out_valid and
  // out_ready are both high at the falling edge (and no flush/reset).
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc=0x%08h instr=0x%08h expected no entry",
                 out_pc, out_instr);
      end else begin
        chk("pop_order", {out_pc, out_instr}, exp_q.pop_front());
      end
    end
  end

  // Offer one entry and hold it until accepted; the expected entry is
  // queued for the monitor at the moment it is offered.
  task automatic send(input logic [31:0] pc, input logic [31:0] ins);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    exp_q.push_back({pc, ins});
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pc=0x%08h never accepted, required acceptance", pc);
    end
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 50 && count != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_count", 64'(count), 64'd0);
  endtask

  bit stream_done;

  initial begin
    // 1. Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP));

    // 2. Fill, hold while full, then drain in order
    out_ready = 1'b0;
    send(32'h0, 32'h0050_0093);
    chk("push1_latency_valid", 64'(out_valid), 64'd1);
    send(32'h4, 32'h0010_8113);
    chk("full_count",    64'(count),    64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_pc    = 32'h8;
    in_instr = 32'h0020_81b3;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_count",  64'(count),  64'd2);
    chk("hold_out_pc", 64'(out_pc), 64'h0);
    chk("hold_ready",  64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(32'h8, 32'h0020_81b3);
    wait_empty();
    out_ready = 1'b0;

    // 3. Simultaneous push and pop
    send(32'h10, 32'h0000_0513);
    chk("simul_pre_count", 64'(count), 64'd1);
    in_valid  = 1'b1;
    in_pc     = 32'h14;
    in_instr  = 32'h0015_0513;
    exp_q.push_back({32'h14, 32'h0015_0513});
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("simul_count",  64'(count),  64'd1);
    chk("simul_out_pc", 64'(out_pc), 64'h14);
    out_ready = 1'b1;
    wait_empty();
    out_ready = 1'b0;

    // 4. Flush with an entry on offer
    send(32'h20, 32'h0000_0613);
    send(32'h24, 32'h0016_0613);
    chk("preflush_count", 64'(count), 64'd2);
    in_valid = 1'b1;
    in_pc    = 32'h28;
    in_instr = 32'h0026_0613;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("flush_count",     64'(count),     64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_instr", 64'(out_instr), 64'(NOP));
    chk("flush_out_pc",    64'(out_pc),    64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;

    // 5. Wrap: 10 entries with out_ready toggling every cycle
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(32'(i * 4), 32'h0000_0093 | (32'(i) << 20));
        stream_done = 1'b1;
      end
      begin
        for (int n = 0; n < 500 && !stream_done; n++) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();
    chk("wrap_all_popped", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;

    // 6. Asynchronous reset between edges
    send(32'h30, 32'h0000_0713);
    send(32'h34, 32'h0017_0713);
    chk("prerst_count", 64'(count), 64'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count",     64'(count),     64'd0);
    chk("arst_out_pc",    64'(out_pc),    64'd0);
    chk("arst_out_instr", 64'(out_instr), 64'(NOP));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
